// File: rtl/cpu_pkg.sv
// Shared CPU constants and the boot loader state encoding.
// Default instruction geometry matches the fetch/decode memory.
package cpu_pkg;

    localparam int INST_LEN_DEF = 17;
    localparam int INST_CAP_DEF = 5;

    typedef enum logic [2:0] {
        S_LOAD,
        S_FILL,
        S_HOLD,
        S_RUN,
        S_ERR,
        S_CSUM
    } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// Boot-time loader: streams a program into inst_mem, zero-fills, releases CPU.
// Optional trailing XOR checksum beat: define INST_LOADER_CHECKSUM_EN.
module inst_loader
    import cpu_pkg::*;
#(
    parameter int INST_LEN    = INST_LEN_DEF,
    parameter int INST_CAP    = INST_CAP_DEF,
    parameter int IA_W        = (INST_CAP > 1) ? $clog2(INST_CAP) : 1,
    parameter int RELEASE_DLY = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic [INST_LEN-1:0] in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                im_we,
    output logic [IA_W-1:0]     im_addr,
    output logic [INST_LEN-1:0] im_wdata,
    output logic                cpu_rstn,
    output logic                done,
    output logic                err
);

    localparam int CW = $clog2(INST_CAP + 1);
    localparam int DW = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

    loader_state_t state, nxt;
    logic [CW-1:0] cnt, cnt_d;
    logic [DW-1:0] dly, dly_d;
    logic          we_d;
    logic [IA_W-1:0]     addr_d;
    logic [INST_LEN-1:0] wdata_d;
    logic          hs;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LAST = S_CSUM;
    logic [INST_LEN-1:0] xacc, xacc_d;
    assign in_ready = (state == S_LOAD) || (state == S_CSUM);
`else
    localparam loader_state_t AFTER_LAST = S_FILL;
    assign in_ready = (state == S_LOAD);
`endif

    assign hs = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_LOAD;
        else       state <= nxt;
    end

    // The FILL exit cycle counts as the first release-delay cycle.
    always_comb begin
        nxt = state;
        unique case (state)
            S_LOAD: begin
                if (hs) begin
                    if (in_last)
                        nxt = AFTER_LAST;
                    else if (cnt == CW'(INST_CAP - 1))
                        nxt = S_ERR;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (hs) nxt = (in_data == xacc) ? S_FILL : S_ERR;
            end
`endif
            S_FILL: begin
                if (cnt == CW'(INST_CAP))
                    nxt = (RELEASE_DLY == 1) ? S_RUN : S_HOLD;
            end
            S_HOLD: begin
                if (dly == DW'(RELEASE_DLY - 1)) nxt = S_RUN;
            end
            S_RUN:   nxt = S_RUN;
            S_ERR:   nxt = S_ERR;
            default: nxt = S_ERR;
        endcase
    end

    always_comb begin
        we_d    = 1'b0;
        addr_d  = im_addr;
        wdata_d = im_wdata;
        cnt_d   = cnt;
        dly_d   = dly;
`ifdef INST_LOADER_CHECKSUM_EN
        xacc_d  = xacc;
`endif
        unique case (state)
            S_LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    addr_d  = cnt[IA_W-1:0];
                    wdata_d = in_data;
                    cnt_d   = cnt + CW'(1);
`ifdef INST_LOADER_CHECKSUM_EN
                    xacc_d  = xacc ^ in_data;
`endif
                end
            end
            S_FILL: begin
                if (cnt < CW'(INST_CAP)) begin
                    we_d    = 1'b1;
                    addr_d  = cnt[IA_W-1:0];
                    wdata_d = '0;
                    cnt_d   = cnt + CW'(1);
                end else begin
                    dly_d   = DW'(1);
                end
            end
            S_HOLD:  dly_d = dly + DW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            dly      <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_rstn <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            dly      <= dly_d;
            im_we    <= we_d;
            im_addr  <= addr_d;
            im_wdata <= wdata_d;
            cpu_rstn <= (nxt == S_RUN);
            done     <= (nxt == S_RUN);
            err      <= (nxt == S_ERR);
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) xacc <= '0;
        else       xacc <= xacc_d;
    end
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write scoreboard.
// Checksum scenarios run when INST_LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;

    localparam int LEN = 17;
    localparam int CAP = 5;
    localparam int DLY = 2;

    typedef struct packed {
        logic [2:0]     a;
        logic [LEN-1:0] d;
    } wr_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           in_valid = 1'b0;
    logic [LEN-1:0] in_data = '0;
    logic           in_last = 1'b0;
    logic           in_ready;
    logic           im_we;
    logic [2:0]     im_addr;
    logic [LEN-1:0] im_wdata;
    logic           cpu_rstn;
    logic           done;
    logic           err;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  last_wr = 0;
    int  ma = 0;
    logic [LEN-1:0] tx = '0;
    wr_t exp_q[$];

    inst_loader #(
        .INST_LEN(LEN), .INST_CAP(CAP), .IA_W(3), .RELEASE_DLY(DLY)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rstn(cpu_rstn), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && im_we) begin
            wr_t e;
            last_wr = cyc;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexp_wr observed=%0h/%0h expected=none",
                       im_addr, im_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(im_addr), 32'(e.a));
                chk("wr_data", 32'(im_wdata), 32'(e.d));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        exp_q.delete();
        ma = 0;
        tx = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic beat(input logic [LEN-1:0] d, input logic l,
                        input bit wr);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        if (in_ready && wr) begin
            exp_q.push_back(wr_t'{a: 3'(ma), d: d});
            ma++;
            tx ^= d;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last = 1'b0;
            @(posedge clk);
        end
    endtask

    // Queue the trailing checksum beat (if built in) and the zero-fill.
    task automatic close_prog();
`ifdef INST_LOADER_CHECKSUM_EN
        beat(tx, 1'b0, 1'b0);
`endif
        while (ma < CAP) begin
            exp_q.push_back(wr_t'{a: 3'(ma), d: '0});
            ma++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        int i;
        i = 0;
        while (i < 40 && !cpu_rstn) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk({tag, "_rel"}, 32'(cpu_rstn), 32'd1);
        chk({tag, "_dly"}, 32'(cyc - last_wr), 32'(DLY));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_q"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        #12;
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'd0);
        chk("rst_wdata", 32'(im_wdata), 32'd0);
        chk("rst_cpu", 32'(cpu_rstn), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        do_reset();

        // Three words, continuous valid.
        beat(17'h00001, 1'b0, 1'b1);
        beat(17'h1FFFF, 1'b0, 1'b1);
        beat(17'h0A5A5, 1'b1, 1'b1);
        close_prog();
        wait_release("w3");
        idle(3);
        chk("w3_hold", 32'(cpu_rstn), 32'd1);

        // Exactly full program: no zero-fill.
        do_reset();
        for (int i = 0; i < CAP; i++)
            beat(LEN'(32'h100 + i * 7), i == CAP - 1, 1'b1);
        close_prog();
        wait_release("w5");

        // Overflow: six words, never last.
        do_reset();
        for (int i = 0; i < CAP; i++)
            beat(LEN'(32'h1F000 + i), 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("ov_err", 32'(err), 32'd1);
        chk("ov_rdy", 32'(in_ready), 32'd0);
        beat(17'h0BEEF, 1'b0, 1'b1);
        idle(4);
        chk("ov_cpu", 32'(cpu_rstn), 32'd0);
        chk("ov_done", 32'(done), 32'd0);
        chk("ov_sticky", 32'(err), 32'd1);
        chk("ov_q", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("ov_rst_err", 32'(err), 32'd0);
        chk("ov_rst_rdy", 32'(in_ready), 32'd1);

        // Gapped valid: idle cycles must not write.
        do_reset();
        beat(17'h00011, 1'b0, 1'b1);
        chk("gap_rdy0", 32'(in_ready), 32'd1);
        idle(1);
        chk("gap_rdy1", 32'(in_ready), 32'd1);
        beat(17'h00022, 1'b0, 1'b1);
        idle(1);
        chk("gap_rdy2", 32'(in_ready), 32'd1);
        beat(17'h00033, 1'b1, 1'b1);
        close_prog();
        wait_release("gap");

        // Async reset while holding the CPU.
        do_reset();
        beat(17'h0C0DE, 1'b1, 1'b1);
        close_prog();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        chk("hold_cpu", 32'(cpu_rstn), 32'd0);
        chk("hold_addr", 32'(im_addr), 32'd4);
        rstn = 1'b0;
        #1;
        chk("ar_addr", 32'(im_addr), 32'd0);
        chk("ar_we", 32'(im_we), 32'd0);
        chk("ar_cpu", 32'(cpu_rstn), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_rdy", 32'(in_ready), 32'd1);
        do_reset();
        beat(17'h12345, 1'b1, 1'b1);
        close_prog();
        wait_release("re1");

`ifdef INST_LOADER_CHECKSUM_EN
        do_reset();
        beat(17'h00003, 1'b0, 1'b1);
        beat(17'h00005, 1'b1, 1'b1);
        chk("cs_model", 32'(tx), 32'h6);
        close_prog();
        wait_release("cs_ok");

        do_reset();
        beat(17'h00003, 1'b0, 1'b1);
        beat(17'h00005, 1'b1, 1'b1);
        beat(17'h00007, 1'b1, 1'b0);
        idle(4);
        chk("cs_bad_err", 32'(err), 32'd1);
        chk("cs_bad_done", 32'(done), 32'd0);
        chk("cs_bad_cpu", 32'(cpu_rstn), 32'd0);
        chk("cs_bad_q", 32'(exp_q.size()), 32'd0);
`endif

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time instruction loader sitting directly upstream of the CPU.
- Accepts a valid/ready stream of INST_LEN-bit instruction words and writes them sequentially into the fetch/decode instruction memory (inst_mem) from address 0.
- Zero-fills unused slots, then holds the CPU in reset for a fixed delay before releasing it.
- Replaces file preloading of inst_mem for synthesizable top-levels.

Parameters:
- INST_LEN, 17, instruction word width in bits.
- INST_CAP, 5, instruction memory depth in words.
- IA_W, $clog2(INST_CAP) (minimum 1), instruction memory address width.
- RELEASE_DLY, 2, cycles between zero-fill completion and CPU reset release; legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  stream word valid.
- in_data  in  INST_LEN  stream instruction word.
- in_last  in  1  marks final program word.
- in_ready  out  1  loader can accept a word.
- im_we  out  1  instruction memory write enable, registered.
- im_addr  out  IA_W  instruction memory write address, registered.
- im_wdata  out  INST_LEN  instruction memory write data, registered.
- cpu_rstn  out  1  active-low reset to the CPU, registered.
- done  out  1  load complete and CPU released.
- err  out  1  overflow or checksum error, sticky until rstn.

Behaviour:
- Reset (async, rstn=0):
  - state=S_LOAD, word counter cnt=0.
  - Outputs: im_we=0, im_addr=0, im_wdata=0, cpu_rstn=0, done=0, err=0.
  - Asserting rstn mid-operation aborts everything; the CPU is re-held in reset.
- States: S_LOAD, S_FILL, S_HOLD, S_RUN, S_ERR (plus S_CSUM with the optional feature).
- in_ready = (state==S_LOAD) [or S_CSUM]; combinational from state only, never from in_valid.
- S_LOAD, on handshake (in_valid&in_ready):
  - Next cycle: im_we=1, im_addr=cnt, im_wdata=in_data; cnt increments.
  - Write latency is exactly 1 cycle after the handshake.
- S_LOAD transitions:
  - Handshake with in_last=1 → S_FILL (→ S_CSUM if feature enabled).
  - Handshake with in_last=0 and cnt==INST_CAP-1 → word still written, then → S_ERR with err=1 (overflow).
  - in_last is only sampled on a handshake.
- S_FILL:
  - Each cycle while cnt<INST_CAP: im_we=1, im_addr=cnt, im_wdata=0, cnt++.
  - When cnt==INST_CAP, → S_HOLD with no write.
  - A program of exactly INST_CAP words passes through S_FILL in one cycle with no writes.
- S_HOLD:
  - Delay counter runs RELEASE_DLY cycles, then → S_RUN.
  - im_we=0 from entry onwards.
- S_RUN: cpu_rstn=1 and done=1, both registered and asserted on the same edge. Terminal until rstn.
- S_ERR: in_ready=0, cpu_rstn=0, done=0, err=1. Terminal until rstn.
- im_we is low in every cycle not listed above.
- cnt width is $clog2(INST_CAP+1); it never wraps.
- in_valid held high in S_HOLD/S_RUN/S_ERR is ignored (no handshake).

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - After the in_last handshake the loader enters S_CSUM with in_ready=1 and accepts exactly one more beat; in_last is ignored on that beat.
  - The beat must equal the XOR of all program words. Match → S_FILL; mismatch → S_ERR with err=1.
  - The checksum beat is never written to memory.
  - Overflow before in_last still → S_ERR.
- Undefined: no S_CSUM state and no XOR register; the in_last handshake goes straight to S_FILL.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum loader_state_t {S_LOAD, S_FILL, S_HOLD, S_RUN, S_ERR, S_CSUM}.
  - Default INST_LEN/INST_CAP constants shared with the CPU.
- No sub-module; the XOR accumulator and release-delay counter are inline. inst_loader instantiates alongside the CPU in the top level.

Test Plan (INST_CAP=5, INST_LEN=17, RELEASE_DLY=2):
- 3 words 0x00001, 0x1FFFF, 0x0A5A5 (last on third), in_valid continuous:
  - Writes at addr 0,1,2 with those values, then addr 3,4 with 0.
  - cpu_rstn and done rise 2 cycles after the addr-4 write; err=0.
- 5 words, last on fifth: no zero-fill writes; cpu_rstn rises RELEASE_DLY cycles after the addr-4 write.
- 6 words, no in_last: 5 writes (addr 0..4), err=1 the cycle after the fifth handshake, in_ready=0 thereafter, cpu_rstn stays 0.
- in_valid toggled 1,0,1,0,1 with last on third word: exactly 3 data writes at consecutive addresses; no writes in idle cycles; in_ready constant 1 in S_LOAD.
- rstn pulsed low during S_HOLD: all outputs return to reset values immediately (async); a fresh 1-word load then completes normally.
- Checksum enabled, words 0x00003, 0x00005, checksum 0x00006: done=1. Same words with checksum 0x00007: err=1, done=0, no write of the checksum beat.
